mmio32: RTL and testbench
=========================

# mmio32

Memory-mapped I/O responder for the single-cycle MINISYS CPU. It services the IORead/IOWrite strobes that the control decoder raises for loads/stores whose address has Alu_Result[31:10] all ones (0xFFFFFC00–0xFFFFFFFF). It owns the LED output register, synchronised switch inputs, debounced push-buttons and a countdown timer. It returns read data in the same cycle so that lw completes within one CPU cycle.

## Interface
Parameters:
- SW_WIDTH, 24, number of switch inputs and LED outputs
- BTN_WIDTH, 5, number of push-buttons
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required before a button value is accepted

Ports:
- clock  in  1  system clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high reset
- IORead  in  1  I/O load strobe from the decoder
- IOWrite  in  1  I/O store strobe from the decoder
- addr_low  in  10  Alu_Result[9:0]; bits [1:0] are ignored (word access only)
- write_data  in  32  store data (rt value)
- read_data  out  32  load data; combinational
- switch_in  in  SW_WIDTH  raw asynchronous switches
- button_in  in  BTN_WIDTH  raw asynchronous buttons, active-high
- led_out  out  SW_WIDTH  registered LED drive
- timer_irq  out  1  copy of the timer expired flag

## Operation
- Register map (offset = addr_low):
  - 0x060 LED, read/write, bits [SW_WIDTH-1:0].
  - 0x070 SWITCH, read-only.
  - 0x074 BUTTON, read-only, debounced value.
  - 0x080 TIMER_LOAD, read/write, 32 bits.
  - 0x084 TIMER_COUNT, read-only.
  - 0x088 TIMER_CTRL, read/write. Bit 0 is enable; bit 1 is auto-reload.
  - 0x08C TIMER_STATUS. Bit 0 is expired. Writing 1 to bit 0 clears it.
- Unmapped offsets read as 0. Writes to unmapped or read-only offsets are ignored.
- Unused upper bits read as 0.
- read_data = 0 whenever IORead = 0. Reads have no side effects.
- Switches: 2-flop synchroniser; SWITCH returns the second stage.
- Buttons: 2-flop synchroniser, then a per-bit debouncer.
  - The debounced value changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back restarts the counter at 0.
- Timer:
  - A write to TIMER_LOAD loads both LOAD and COUNT with write_data.
  - When enable = 1 and COUNT > 1, COUNT decrements by 1 each cycle.
  - When enable = 1 and COUNT == 1, expired is set, and COUNT becomes LOAD if auto-reload = 1, otherwise 0.
  - When enable = 1 and COUNT == 0, nothing happens and expired is not set.
  - Clearing enable freezes COUNT.
- Simultaneous events:
  - An expiry event and a W1C of expired in the same cycle: set wins, so expired stays 1.
  - A TIMER_LOAD write and a decrement in the same cycle: the write wins.
  - IORead and IOWrite both high (not produced by the decoder): the write is performed, and read_data shows the pre-write value.

## Timing
- Read latency: 0. read_data is valid in the same cycle IORead is asserted and reflects register state before the coming edge.
- Writes take effect at the rising edge where IOWrite = 1. The new value is readable the following cycle.
- Switch latency: 2 cycles from switch_in to SWITCH.
- Button latency: 2 + DEBOUNCE_CYCLES cycles from a clean edge to BUTTON.
- A timer loaded with N and enabled sets expired N cycles after the enable write edge. timer_irq follows expired with no added delay.
- Reset (synchronous) clears:
  - led_out, timer_irq, and read_data (when IORead = 0).
  - Synchroniser stages, debounced values and debounce counters.
  - LOAD, COUNT, CTRL and expired.
- Reset mid-count stops the timer at 0 on the next edge.

## Configuration
- MMIO_TIMER_EN defined: the timer, its four registers and timer_irq behave as described above.
- MMIO_TIMER_EN undefined:
  - No timer logic is synthesised.
  - Offsets 0x080–0x08C read as 0 and writes to them are ignored.
  - timer_irq is tied to 0.

## Structure
- Package mmio32_pkg holds:
  - The register offset localparams (LED, SWITCH, BUTTON, TIMER_LOAD/COUNT/CTRL/STATUS).
  - CTRL bit indices (enable = 0, auto-reload = 1).
  - The STATUS expired bit index.
  - The I/O base constant 22'h3FFFFF.
- One sub-module, button_debounce: a single-bit synchroniser plus debounce counter parameterised by DEBOUNCE_CYCLES. It is instantiated BTN_WIDTH times in a generate loop.
- The read mux, LED register and timer stay in mmio32.

## Test plan
- After reset: IOWrite to 0x060 with 0x00A5A5A5 → led_out = 0xA5A5A5 next cycle. An IORead of 0x060 in that cycle returns 0x00A5A5A5, and read_data = 0 when IORead is low.
- switch_in = 0x123456 held → an IORead of 0x070 returns 0x00123456 from the 2nd cycle onward. A write to 0x070 leaves the value unchanged.
- Buttons, with DEBOUNCE_CYCLES = 4: button_in[0] pulses high for 3 cycles → BUTTON stays 0. Held high for 10 cycles → BUTTON = 0x1 at cycle 6.
- One-shot timer: write LOAD = 5, then CTRL = 0x1 → COUNT reads 4,3,2,1, then expired = 1 and COUNT = 0, timer_irq = 1. Writing 0x1 to 0x08C clears it.
- Auto-reload timer: LOAD = 3, CTRL = 0x3 → expired sets every 3 cycles. A W1C in the same cycle as an expiry leaves expired = 1.
- Unmapped read of 0x3FC returns 0. Asserting reset mid-count zeroes COUNT, CTRL and led_out on the next edge. A build without MMIO_TIMER_EN returns 0 at 0x084.

Source files
------------

// File: rtl/mmio32_pkg.sv
// Shared constants for the MINISYS memory-mapped I/O responder.
package mmio32_pkg;

    localparam logic [21:0] IO_BASE = 22'h3FFFFF;

    localparam logic [9:0] OFF_LED          = 10'h060;
    localparam logic [9:0] OFF_SWITCH       = 10'h070;
    localparam logic [9:0] OFF_BUTTON       = 10'h074;
    localparam logic [9:0] OFF_TIMER_LOAD   = 10'h080;
    localparam logic [9:0] OFF_TIMER_COUNT  = 10'h084;
    localparam logic [9:0] OFF_TIMER_CTRL   = 10'h088;
    localparam logic [9:0] OFF_TIMER_STATUS = 10'h08C;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int STATUS_EXPIRED   = 0;

    typedef struct packed {
        logic auto_reload;
        logic enable;
    } timer_ctrl_t;

    // Word-granular match: byte-lane bits [1:0] never take part in decode.
    function automatic logic word_hit(input logic [9:0] addr, input logic [9:0] off);
        return addr[9:2] == off[9:2];
    endfunction

endpackage

// File: rtl/mmio32_button_debounce.sv
// One push-button: 2-flop synchroniser followed by a stable-count debouncer.
module button_debounce
    import mmio32_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic value
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            stable_cnt <= '0;
            value      <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            // Accept the new level on the last of DEBOUNCE_CYCLES differing cycles.
            if (sync1 != value) begin
                if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    value      <= sync1;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mmio32.sv
// MINISYS MMIO responder: LEDs, switches, debounced buttons and an optional
// countdown timer built only when MMIO_TIMER_EN is defined.
module mmio32
    import mmio32_pkg::*;
#(
    parameter int SW_WIDTH        = 24,
    parameter int BTN_WIDTH       = 5,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 IORead,
    input  logic                 IOWrite,
    input  logic [9:0]           addr_low,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    input  logic [SW_WIDTH-1:0]  switch_in,
    input  logic [BTN_WIDTH-1:0] button_in,
    output logic [SW_WIDTH-1:0]  led_out,
    output logic                 timer_irq
);

    logic [SW_WIDTH-1:0]  sw_sync0;
    logic [SW_WIDTH-1:0]  sw_sync1;
    logic [BTN_WIDTH-1:0] btn_value;
    logic                 unused_bits;

    assign unused_bits = ^{addr_low[1:0], write_data};

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_sync0 <= '0;
            sw_sync1 <= '0;
            led_out  <= '0;
        end else begin
            sw_sync0 <= switch_in;
            sw_sync1 <= sw_sync0;
            if (IOWrite && word_hit(addr_low, OFF_LED))
                led_out <= write_data[SW_WIDTH-1:0];
        end
    end

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (button_in[i]),
            .value(btn_value[i])
        );
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_load;
    logic [31:0] timer_count;
    timer_ctrl_t timer_ctrl;
    logic        timer_expired;
    logic        expire_evt;

    assign expire_evt = timer_ctrl.enable && (timer_count == 32'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_load    <= '0;
            timer_count   <= '0;
            timer_ctrl    <= '0;
            timer_expired <= 1'b0;
        end else begin
            if (IOWrite && word_hit(addr_low, OFF_TIMER_CTRL)) begin
                timer_ctrl.enable      <= write_data[CTRL_ENABLE];
                timer_ctrl.auto_reload <= write_data[CTRL_AUTO_RELOAD];
            end
            // A software load overrides whatever the counter would do this edge.
            if (IOWrite && word_hit(addr_low, OFF_TIMER_LOAD)) begin
                timer_load  <= write_data;
                timer_count <= write_data;
            end else if (timer_ctrl.enable && timer_count > 32'd1) begin
                timer_count <= timer_count - 32'd1;
            end else if (expire_evt) begin
                timer_count <= timer_ctrl.auto_reload ? timer_load : 32'd0;
            end
            // Set beats a simultaneous write-1-to-clear.
            if (expire_evt)
                timer_expired <= 1'b1;
            else if (IOWrite && word_hit(addr_low, OFF_TIMER_STATUS) && write_data[STATUS_EXPIRED])
                timer_expired <= 1'b0;
        end
    end

    assign timer_irq = timer_expired;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        if (IORead) begin
            if (word_hit(addr_low, OFF_LED))
                read_data[SW_WIDTH-1:0] = led_out;
            else if (word_hit(addr_low, OFF_SWITCH))
                read_data[SW_WIDTH-1:0] = sw_sync1;
            else if (word_hit(addr_low, OFF_BUTTON))
                read_data[BTN_WIDTH-1:0] = btn_value;
`ifdef MMIO_TIMER_EN
            else if (word_hit(addr_low, OFF_TIMER_LOAD))
                read_data = timer_load;
            else if (word_hit(addr_low, OFF_TIMER_COUNT))
                read_data = timer_count;
            else if (word_hit(addr_low, OFF_TIMER_CTRL))
                read_data[1:0] = timer_ctrl;
            else if (word_hit(addr_low, OFF_TIMER_STATUS))
                read_data[STATUS_EXPIRED] = timer_expired;
`endif
        end
    end

endmodule

// File: tb/tb_mmio32.sv
// Directed bench for mmio32: register-map vectors plus switch, button and timer sequences.
module tb_mmio32;

    logic        clock = 1'b0;
    logic        reset;
    logic        IORead;
    logic        IOWrite;
    logic [9:0]  addr_low;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [23:0] switch_in;
    logic [4:0]  button_in;
    logic [23:0] led_out;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    mmio32 #(
        .SW_WIDTH       (24),
        .BTN_WIDTH      (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .IORead    (IORead),
        .IOWrite   (IOWrite),
        .addr_low  (addr_low),
        .write_data(write_data),
        .read_data (read_data),
        .switch_in (switch_in),
        .button_in (button_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [23:0] exp_led;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        IORead     = 1'b0;
        IOWrite    = 1'b1;
        addr_low   = a;
        write_data = d;
        tick(1);
        IOWrite    = 1'b0;
    endtask

    task automatic rchk(input string name, input logic [9:0] a, input logic [31:0] exp);
        IORead   = 1'b1;
        IOWrite  = 1'b0;
        addr_low = a;
        #1;
        chk(name, read_data, exp);
        IORead = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        IORead     = 1'b0;
        IOWrite    = 1'b0;
        addr_low   = '0;
        write_data = '0;
        switch_in  = 24'h123456;
        button_in  = '0;

        //                rd    wr    addr     wdata         exp_rd        exp_led
        vecs[0]  = '{1'b1, 1'b0, 10'h060, 32'h0,        32'h0,        24'h000000};
        vecs[1]  = '{1'b0, 1'b1, 10'h060, 32'h00A5A5A5, 32'h0,        24'hA5A5A5};
        vecs[2]  = '{1'b1, 1'b0, 10'h060, 32'h0,        32'h00A5A5A5, 24'hA5A5A5};
        vecs[3]  = '{1'b0, 1'b0, 10'h060, 32'h0,        32'h0,        24'hA5A5A5};
        vecs[4]  = '{1'b1, 1'b0, 10'h070, 32'h0,        32'h00123456, 24'hA5A5A5};
        vecs[5]  = '{1'b0, 1'b1, 10'h070, 32'hFFFFFFFF, 32'h0,        24'hA5A5A5};
        vecs[6]  = '{1'b1, 1'b0, 10'h070, 32'h0,        32'h00123456, 24'hA5A5A5};
        vecs[7]  = '{1'b1, 1'b0, 10'h3FC, 32'h0,        32'h0,        24'hA5A5A5};
        vecs[8]  = '{1'b1, 1'b1, 10'h060, 32'h00FF00FF, 32'h00A5A5A5, 24'hFF00FF};
        vecs[9]  = '{1'b1, 1'b0, 10'h060, 32'h0,        32'h00FF00FF, 24'hFF00FF};
        vecs[10] = '{1'b0, 1'b1, 10'h063, 32'h00111111, 32'h0,        24'h111111};
        vecs[11] = '{1'b1, 1'b0, 10'h074, 32'h0,        32'h0,        24'h111111};
        vecs[12] = '{1'b0, 1'b1, 10'h060, 32'hFFFFFFFF, 32'h0,        24'hFFFFFF};

        tick(2);
        reset = 1'b0;
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_irq", 32'(timer_irq), 32'h0);

        for (int i = 0; i < 13; i++) begin
            IORead     = vecs[i].rd_en;
            IOWrite    = vecs[i].wr_en;
            addr_low   = vecs[i].addr;
            write_data = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
            tick(1);
            chk($sformatf("vec%0d_led", i), 32'(led_out), 32'(vecs[i].exp_led));
        end
        IORead  = 1'b0;
        IOWrite = 1'b0;
        rchk("led_upper_zero", 10'h060, 32'h00FFFFFF);

        // Switch synchroniser: two edges before the new value is visible.
        switch_in = 24'h0ABCDE;
        rchk("sw_lat0", 10'h070, 32'h00123456);
        tick(1);
        rchk("sw_lat1", 10'h070, 32'h00123456);
        tick(1);
        rchk("sw_lat2", 10'h070, 32'h000ABCDE);

        // 3-cycle glitch never reaches the debounced value.
        button_in[0] = 1'b1;
        tick(3);
        button_in[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rchk($sformatf("btn_glitch_%0d", k), 10'h074, 32'h0);
            tick(1);
        end

        // Clean press: debounced after 2 + 4 edges, release likewise.
        button_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            rchk($sformatf("btn_press_%0d", k), 10'h074, (k >= 6) ? 32'h1 : 32'h0);
        end
        button_in[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            rchk($sformatf("btn_release_%0d", k), 10'h074, (k >= 6) ? 32'h0 : 32'h1);
        end

`ifdef MMIO_TIMER_EN
        // One-shot: LOAD=5, enable -> 4,3,2,1 then expired.
        wr(10'h080, 32'd5);
        rchk("tload_rd", 10'h080, 32'd5);
        rchk("tcount_loaded", 10'h084, 32'd5);
        wr(10'h088, 32'h1);
        rchk("tctrl_rd", 10'h088, 32'h1);
        rchk("tcount_en_edge", 10'h084, 32'd5);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            rchk($sformatf("os_count_%0d", k), 10'h084, 32'(5 - k));
            rchk($sformatf("os_status_%0d", k), 10'h08C, 32'h0);
        end
        tick(1);
        rchk("os_count_exp", 10'h084, 32'd0);
        rchk("os_status_exp", 10'h08C, 32'h1);
        chk("os_irq_exp", 32'(timer_irq), 32'h1);
        tick(1);
        rchk("os_count_hold", 10'h084, 32'd0);
        rchk("os_status_hold", 10'h08C, 32'h1);
        wr(10'h08C, 32'h1);
        rchk("os_w1c", 10'h08C, 32'h0);
        chk("os_irq_clr", 32'(timer_irq), 32'h0);

        // Auto-reload every 3 cycles; W1C colliding with expiry loses.
        wr(10'h088, 32'h0);
        wr(10'h080, 32'd3);
        wr(10'h088, 32'h3);
        tick(1);
        rchk("ar_count_1", 10'h084, 32'd2);
        tick(1);
        rchk("ar_count_2", 10'h084, 32'd1);
        tick(1);
        rchk("ar_count_3", 10'h084, 32'd3);
        rchk("ar_status_3", 10'h08C, 32'h1);
        wr(10'h08C, 32'h1);
        rchk("ar_status_clr", 10'h08C, 32'h0);
        rchk("ar_count_4", 10'h084, 32'd2);
        tick(1);
        rchk("ar_count_5", 10'h084, 32'd1);
        wr(10'h08C, 32'h1);
        rchk("ar_set_wins", 10'h08C, 32'h1);
        rchk("ar_count_6", 10'h084, 32'd3);
        chk("ar_irq", 32'(timer_irq), 32'h1);

        // LOAD write beats the decrement on the same edge.
        wr(10'h080, 32'd10);
        rchk("load_wins", 10'h084, 32'd10);
        tick(1);
        rchk("load_then_dec", 10'h084, 32'd9);
`else
        wr(10'h080, 32'd5);
        wr(10'h088, 32'h1);
        rchk("notimer_load", 10'h080, 32'h0);
        rchk("notimer_count", 10'h084, 32'h0);
        tick(6);
        rchk("notimer_status", 10'h08C, 32'h0);
        chk("notimer_irq", 32'(timer_irq), 32'h0);
`endif

        // Synchronous reset mid-activity.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        chk("rst_read_idle", read_data, 32'h0);
        rchk("rst_sw_cleared", 10'h070, 32'h0);
`ifdef MMIO_TIMER_EN
        rchk("rst_count", 10'h084, 32'h0);
        rchk("rst_ctrl", 10'h088, 32'h0);
        rchk("rst_load", 10'h080, 32'h0);
        rchk("rst_status", 10'h08C, 32'h0);

        // Enabled with COUNT == 0: no expiry.
        wr(10'h088, 32'h1);
        tick(3);
        rchk("zero_count_status", 10'h08C, 32'h0);
        rchk("zero_count_count", 10'h084, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
